soda_machine: RTL and testbench
===============================

// Module: soda_machine
// PURPOSE
//  Coin-operated soda vending controller with an IEEE 1149.1-style JTAG TAP.
//  Accepts nickels, dimes and quarters; dispenses at PRICE and returns change one coin per cycle.
//  The TAP gives board-level identification through the IDCODE and BYPASS instructions.
//  Top-level leaf block; the vending FSM and the TAP share no state.
// PARAMETERS
//  PRICE     15             soda price in cents; must be a multiple of 5 and at most 25
//  IDCODE    32'h50DA_1001  JTAG ID value; bit0 must be 1
//  IR_IDCODE 4'b1011        opcode for the IDCODE instruction
//  IR_BYPASS 4'b1111        opcode for the BYPASS instruction
// PORTS
//  clk       in   1  functional clock; all vending logic is on the rising edge
//  rst       in   1  asynchronous, active-high reset of the vending logic
//  n         in   1  nickel (5c) inserted, sampled each clk
//  d         in   1  dime (10c) inserted, sampled each clk
//  q         in   1  quarter (25c) inserted, sampled each clk
//  n_out     out  1  return one nickel this cycle
//  d_out     out  1  return one dime this cycle
//  dispense  out  1  one-cycle pulse: release a soda
//  tdi       in   1  JTAG data in
//  tdo       out  1  JTAG data out
//  tck       in   1  JTAG test clock, asynchronous to clk
//  tms       in   1  JTAG mode select, sampled on the tck rising edge
//  trst_n    in   1  JTAG asynchronous active-low TAP reset
// BEHAVIOUR
//  Interface: single functional clock clk; reset rst is asynchronous and active-high.
//  Vending logic:
//  - rst=1 forces credit=0, state IDLE and n_out=d_out=dispense=0.
//  - The outputs are registered.
//  - IDLE/COLLECT: each clk with a coin input high adds one coin to credit.
//    - Priority is q>d>n; only one coin is counted per cycle.
//    - A level held high counts every cycle.
//  - When credit>=PRICE: dispense=1 for exactly 1 cycle and change=credit-PRICE, then enter CHANGE.
//  - CHANGE: one coin per cycle, greedy: d_out=1 while change>=10, otherwise n_out=1 while change>=5.
//    - n_out and d_out are never high together.
//    - When change reaches 0, return to IDLE with credit=0.
//    - Coins inserted during the dispense or CHANGE cycles are ignored (rejected).
//  - Maximum credit is PRICE-5+25; the credit register is 6 bits and cannot overflow.
//  - rst asserted mid-transaction forfeits credit and pending change.
//  TAP (tck domain):
//  - Standard 16-state TAP FSM driven by tms on the rising edge of tck.
//  - trst_n=0, or 5 consecutive tms=1 edges, gives Test-Logic-Reset.
//  - In Test-Logic-Reset, IR=IR_IDCODE.
//  - Instruction register, 4 bits:
//    - Capture-IR loads 4'b0001.
//    - Shift-IR shifts tdi in at the MSB, LSB first.
//    - Update-IR latches the value.
//  - Capture-DR loads the selected data register:
//    - IDCODE register: 32-bit, loaded with IDCODE.
//    - BYPASS register: 1 bit, loaded with 0.
//  - Shift-DR shifts LSB first, tdi in at the MSB.
//  - Any opcode other than IR_IDCODE selects BYPASS.
//  - tdo is updated on the falling edge of tck with the LSB of the active shift register.
//  - tdo=0 outside Shift-IR/Shift-DR.
//  - Path from reset to Shift-IR: tms 0,1,1,0,0.
//  - After 4 IR bits (the last with tms=1), tms 1,1,0,0 reaches Shift-DR.
//  - The first tdo bit is sampled at the next rising edge.
// TESTING
//  - rst=1, all coins=1 -> n_out=d_out=dispense=0 every cycle.
//  - Release rst; pulse n,n,n (1 cycle each) -> dispense pulse on the cycle after the 3rd nickel; no change.
//  - Pulse d then q (35c) -> dispense, then d_out for 2 consecutive cycles, then IDLE.
//  - Pulse q alone (25c) -> dispense, then d_out for 1 cycle; d and q=1 together count only q.
//  - TAP: trst_n pulse, tms=1x5, IR shift 1,1,0,1, then 32 Shift-DR cycles -> tdo bits assemble to 32'h50DA_1001.
//  - TAP: IR 1,1,1,1 (BYPASS), shift tdi=1 -> tdo=0 first cycle, then echoes tdi delayed 1 tck.

Source files
------------

// File: rtl/soda_machine.sv
// Soda vending controller with a small JTAG TAP (IDCODE / BYPASS).
// The vending FSM runs on clk/rst; the TAP runs on tck/trst_n. The two
// domains share no state.
//
// Vending FSM
//   state      | meaning
//   V_IDLE     | no credit, waiting for the first coin
//   V_COLLECT  | credit > 0 but below price, accepting coins
//   V_DISPENSE | dispense pulse is on the output this cycle
//   V_CHANGE   | a change coin is on the output this cycle
//
// TAP FSM: the standard 16-state IEEE 1149.1 controller.
module soda_machine #(
    parameter int unsigned PRICE     = 15,
    parameter logic [31:0] IDCODE    = 32'h50DA_1001,
    parameter logic [3:0]  IR_IDCODE = 4'b1011,
    parameter logic [3:0]  IR_BYPASS = 4'b1111
) (
    input  logic clk,
    input  logic rst,
    input  logic n,
    input  logic d,
    input  logic q,
    output logic n_out,
    output logic d_out,
    output logic dispense,
    input  logic tdi,
    output logic tdo,
    input  logic tck,
    input  logic tms,
    input  logic trst_n
);

    localparam logic [5:0] PRICE_C = 6'(PRICE);
    localparam logic [5:0] NICKEL  = 6'd5;
    localparam logic [5:0] DIME    = 6'd10;
    localparam logic [5:0] QUARTER = 6'd25;

    typedef enum logic [1:0] {V_IDLE, V_COLLECT, V_DISPENSE, V_CHANGE} vend_state_t;

    vend_state_t vstate_q, vstate_d;
    logic [5:0]  credit_q, credit_d;
    logic [5:0]  change_q, change_d;
    logic        n_out_q, n_out_d;
    logic        d_out_q, d_out_d;
    logic        disp_q, disp_d;
    logic [5:0]  coin_val;
    logic [5:0]  sum_w;

    // Vending state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vstate_q <= V_IDLE;
            credit_q <= '0;
            change_q <= '0;
            n_out_q  <= 1'b0;
            d_out_q  <= 1'b0;
            disp_q   <= 1'b0;
        end else begin
            vstate_q <= vstate_d;
            credit_q <= credit_d;
            change_q <= change_d;
            n_out_q  <= n_out_d;
            d_out_q  <= d_out_d;
            disp_q   <= disp_d;
        end
    end

    // Coin valuation with q > d > n priority; only one coin per cycle.
    always_comb begin
        coin_val = '0;
        if (q)      coin_val = QUARTER;
        else if (d) coin_val = DIME;
        else if (n) coin_val = NICKEL;
        sum_w = credit_q + coin_val;
    end

    // Next-state: credit is below price before any add, so sum_w tops out
    // at PRICE-5+25 and never wraps the 6-bit register. In V_CHANGE,
    // change_q already excludes the coin currently on the output.
    always_comb begin
        vstate_d = vstate_q;
        credit_d = credit_q;
        change_d = change_q;
        n_out_d  = 1'b0;
        d_out_d  = 1'b0;
        disp_d   = 1'b0;
        unique case (vstate_q)
            V_IDLE, V_COLLECT: begin
                if (coin_val != 6'd0) begin
                    if (sum_w >= PRICE_C) begin
                        disp_d   = 1'b1;
                        change_d = sum_w - PRICE_C;
                        credit_d = '0;
                        vstate_d = V_DISPENSE;
                    end else begin
                        credit_d = sum_w;
                        vstate_d = V_COLLECT;
                    end
                end
            end
            V_DISPENSE, V_CHANGE: begin
                if (change_q >= DIME) begin
                    d_out_d  = 1'b1;
                    change_d = change_q - DIME;
                    vstate_d = V_CHANGE;
                end else if (change_q >= NICKEL) begin
                    n_out_d  = 1'b1;
                    change_d = change_q - NICKEL;
                    vstate_d = V_CHANGE;
                end else begin
                    change_d = '0;
                    credit_d = '0;
                    vstate_d = V_IDLE;
                end
            end
            default: vstate_d = V_IDLE;
        endcase
    end

    assign n_out    = n_out_q;
    assign d_out    = d_out_q;
    assign dispense = disp_q;

    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
    } tap_state_t;

    tap_state_t tap_q, tap_d;
    logic [3:0]  ir_q;
    logic [3:0]  ir_sr_q;
    logic [31:0] id_sr_q;
    logic        bp_q;
    logic        dr_lsb;
    logic        tdo_q;

    // TAP state register.
    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) tap_q <= TLR;
        else         tap_q <= tap_d;
    end

    // TAP next-state from tms.
    always_comb begin
        tap_d = tap_q;
        unique case (tap_q)
            TLR:     tap_d = tms ? TLR    : RTI;
            RTI:     tap_d = tms ? SEL_DR : RTI;
            SEL_DR:  tap_d = tms ? SEL_IR : CAP_DR;
            CAP_DR:  tap_d = tms ? EX1_DR : SH_DR;
            SH_DR:   tap_d = tms ? EX1_DR : SH_DR;
            EX1_DR:  tap_d = tms ? UPD_DR : PAU_DR;
            PAU_DR:  tap_d = tms ? EX2_DR : PAU_DR;
            EX2_DR:  tap_d = tms ? UPD_DR : SH_DR;
            UPD_DR:  tap_d = tms ? SEL_DR : RTI;
            SEL_IR:  tap_d = tms ? TLR    : CAP_IR;
            CAP_IR:  tap_d = tms ? EX1_IR : SH_IR;
            SH_IR:   tap_d = tms ? EX1_IR : SH_IR;
            EX1_IR:  tap_d = tms ? UPD_IR : PAU_IR;
            PAU_IR:  tap_d = tms ? EX2_IR : PAU_IR;
            EX2_IR:  tap_d = tms ? UPD_IR : SH_IR;
            UPD_IR:  tap_d = tms ? SEL_DR : RTI;
            default: tap_d = TLR;
        endcase
    end

    // Instruction and data registers, acting on the current TAP state.
    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            ir_q    <= IR_IDCODE;
            ir_sr_q <= '0;
            id_sr_q <= '0;
            bp_q    <= 1'b0;
        end else begin
            unique case (tap_q)
                TLR:    ir_q    <= IR_IDCODE;
                CAP_IR: ir_sr_q <= 4'b0001;
                SH_IR:  ir_sr_q <= {tdi, ir_sr_q[3:1]};
                UPD_IR: ir_q    <= ir_sr_q;
                CAP_DR: begin
                    id_sr_q <= IDCODE;
                    bp_q    <= 1'b0;
                end
                SH_DR: begin
                    if (ir_q == IR_IDCODE) id_sr_q <= {tdi, id_sr_q[31:1]};
                    else                   bp_q    <= tdi;
                end
                default: ;
            endcase
        end
    end

    // Data-register output select; unknown opcodes fall back to BYPASS.
    always_comb begin
        dr_lsb = bp_q;
        case (ir_q)
            IR_IDCODE: dr_lsb = id_sr_q[0];
            IR_BYPASS: dr_lsb = bp_q;
            default:   dr_lsb = bp_q;
        endcase
    end

    // tdo changes on the falling edge so the board samples it on the next rise.
    always_ff @(negedge tck or negedge trst_n) begin
        if (!trst_n)              tdo_q <= 1'b0;
        else if (tap_q == SH_IR)  tdo_q <= ir_sr_q[0];
        else if (tap_q == SH_DR)  tdo_q <= dr_lsb;
        else                      tdo_q <= 1'b0;
    end

    assign tdo = tdo_q;

endmodule

// File: tb/tb_soda_machine.sv
// Directed bench for soda_machine: vending vector table, async-reset
// sequence, and TAP IDCODE / BYPASS scans.
module tb_soda_machine;

    logic clk, rst, n, d, q;
    logic n_out, d_out, dispense;
    logic tdi, tdo, tck, tms, trst_n;

    int n_cmp;
    int n_fail;

    soda_machine dut (
        .clk(clk), .rst(rst), .n(n), .d(d), .q(q),
        .n_out(n_out), .d_out(d_out), .dispense(dispense),
        .tdi(tdi), .tdo(tdo), .tck(tck), .tms(tms), .trst_n(trst_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       rst;
        logic       n;
        logic       d;
        logic       q;
        logic [2:0] exp;   // {n_out, d_out, dispense}
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic nn, input logic dd, input logic qq,
                       input logic [2:0] e);
        vec_t v;
        v.rst = r; v.n = nn; v.d = dd; v.q = qq; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic tck_cycle(input logic tms_v, input logic tdi_v, output logic tdo_v);
        tms = tms_v;
        tdi = tdi_v;
        #5;
        tdo_v = tdo;
        tck = 1'b1;
        #5;
        tck = 1'b0;
    endtask

    task automatic tms_seq(input logic [7:0] bits, input int len);
        logic b;
        for (int i = 0; i < len; i++) tck_cycle(bits[i], 1'b0, b);
    endtask

    initial begin
        logic [31:0] word;
        logic [3:0]  ir_out;
        logic [3:0]  irb;
        logic [5:0]  bp_in;
        logic [5:0]  bp_exp;
        logic        b;

        n_cmp = 0; n_fail = 0;
        rst = 1'b1; n = 1'b1; d = 1'b1; q = 1'b1;
        tck = 1'b0; tms = 1'b1; tdi = 1'b0; trst_n = 1'b1;

        // reset with every coin held high
        add(1,1,1,1,3'b000); add(1,1,1,1,3'b000); add(1,1,1,1,3'b000);
        add(0,0,0,0,3'b000);
        // three nickels
        add(0,1,0,0,3'b000); add(0,1,0,0,3'b000); add(0,1,0,0,3'b001);
        add(0,0,0,0,3'b000); add(0,0,0,0,3'b000);
        // dime + quarter = 35 -> two dimes back
        add(0,0,1,0,3'b000); add(0,0,0,1,3'b001);
        add(0,0,0,0,3'b010); add(0,0,0,0,3'b010); add(0,0,0,0,3'b000);
        // quarter alone; coins during dispense/change ignored; d+q counts as q
        add(0,0,0,1,3'b001); add(0,0,1,1,3'b010); add(0,0,1,1,3'b000);
        add(0,0,1,1,3'b001); add(0,0,0,0,3'b010); add(0,0,0,0,3'b000);
        // nickel + quarter = 30 -> dime then nickel
        add(0,1,0,0,3'b000); add(0,0,0,1,3'b001); add(0,1,0,0,3'b010);
        add(0,0,0,0,3'b100); add(0,0,0,0,3'b000);
        // dime + nickel exact price
        add(0,0,1,0,3'b000); add(0,1,0,0,3'b001); add(0,0,0,0,3'b000);
        // nickel level held counts every cycle
        add(0,1,0,0,3'b000); add(0,1,0,0,3'b000); add(0,1,0,0,3'b001);
        add(0,0,0,0,3'b000);
        // reset mid-collect forfeits the dime
        add(0,0,1,0,3'b000); add(1,0,0,0,3'b000);
        add(0,1,0,0,3'b000); add(0,1,0,0,3'b000); add(0,1,0,0,3'b001);
        add(0,0,0,0,3'b000);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst; n = vecs[i].n; d = vecs[i].d; q = vecs[i].q;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), {29'd0, n_out, d_out, dispense}, {29'd0, vecs[i].exp});
        end

        // asynchronous reset in the middle of change return
        @(negedge clk); n = 0; d = 1; q = 0;
        @(negedge clk); d = 0; q = 1;
        @(posedge clk); #1;
        check("async_disp", {29'd0, n_out, d_out, dispense}, 32'b001);
        @(negedge clk); q = 0;
        @(posedge clk); #1;
        check("async_dout", {29'd0, n_out, d_out, dispense}, 32'b010);
        #2 rst = 1'b1;
        #1 check("async_clear", {29'd0, n_out, d_out, dispense}, 32'b000);
        @(negedge clk); rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check($sformatf("async_after%0d", k), {29'd0, n_out, d_out, dispense}, 32'b000);
        end

        // TAP: IDCODE read after explicit IR load
        trst_n = 1'b0; #3;
        check("tdo_trst", {31'd0, tdo}, 32'd0);
        trst_n = 1'b1; #2;
        tms_seq(8'b0001_1111, 5);
        tms_seq(8'b0000_0110, 5);          // TLR -> Shift-IR
        irb = 4'b1011;
        for (int i = 0; i < 4; i++) begin
            tck_cycle(i == 3, irb[i], b);
            ir_out[i] = b;
        end
        check("ir_capture", {28'd0, ir_out}, 32'h1);
        tms_seq(8'b0000_0011, 4);          // Exit1-IR -> Shift-DR
        for (int i = 0; i < 32; i++) begin
            tck_cycle(1'b0, 1'b0, b);
            word[i] = b;
        end
        check("idcode", word, 32'h50DA_1001);
        tck_cycle(1'b1, 1'b0, b);
        tck_cycle(1'b1, 1'b0, b);
        check("tdo_idle", {31'd0, b}, 32'd0);
        tck_cycle(1'b0, 1'b0, b);          // Update-DR -> RTI

        // TAP: BYPASS
        tms_seq(8'b0000_0011, 4);          // RTI -> Shift-IR
        irb = 4'b1111;
        for (int i = 0; i < 4; i++) tck_cycle(i == 3, irb[i], b);
        tms_seq(8'b0000_0011, 4);
        bp_in  = 6'b101101;
        bp_exp = 6'b011010;
        for (int i = 0; i < 6; i++) begin
            tck_cycle(1'b0, bp_in[i], b);
            check($sformatf("bypass%0d", i), {31'd0, b}, {31'd0, bp_exp[i]});
        end

        // TAP: five tms=1 edges restore IDCODE as the default instruction
        tms_seq(8'b0001_1111, 5);
        tms_seq(8'b0000_0010, 4);          // TLR -> Shift-DR
        for (int i = 0; i < 32; i++) begin
            tck_cycle(1'b0, 1'b0, b);
            word[i] = b;
        end
        check("idcode_tlr", word, 32'h50DA_1001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
